// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: handshake bundle between the pipeline sequencer and the datapath.
interface pipe_ctrl_if #(
    parameter int STAGES = 5,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 16
);
    localparam int RW = $clog2(NREGS);
    logic              if_resp, mem_stall, br_taken;
    logic              id_we, id_is_load, id_src_a_en, id_src_b_en;
    logic [RW-1:0]     id_dest, id_src_a, id_src_b;
    logic              load_pc, pc_sel, hazard_stall, retire_we;
    logic [RW-1:0]     retire_dest;
    logic [STAGES-2:0] pipe_load, pipe_valid;
    logic [CNT_W-1:0]  stall_count, flush_count;
    modport master (
        output if_resp, mem_stall, br_taken, id_we, id_is_load, id_src_a_en, id_src_b_en,
        output id_dest, id_src_a, id_src_b,
        input  load_pc, pc_sel, hazard_stall, retire_we, retire_dest,
        input  pipe_load, pipe_valid, stall_count, flush_count
    );
    modport slave (
        input  if_resp, mem_stall, br_taken, id_we, id_is_load, id_src_a_en, id_src_b_en,
        input  id_dest, id_src_a, id_src_b,
        output load_pc, pc_sel, hazard_stall, retire_we, retire_dest,
        output pipe_load, pipe_valid, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipe-register valid/load sequencing, branch flush, register interlock and perf counters.
module pipe_ctrl #(
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3,
    parameter int BR_STAGE  = 3,
    parameter int FORWARD   = 0,
    parameter int RF_BYPASS = 0,
    parameter int NREGS     = 8,
    parameter int CNT_W     = 16
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave pif
);
    localparam int RW   = $clog2(NREGS);
    localparam int L    = STAGES - 1;
    localparam int LAST = RF_BYPASS != 0 ? STAGES - 2 : STAGES - 1;
    logic [L:1]         valid_q, valid_d, hold_w, bub_w;
    logic [L:2]         we_q, we_d, we_sh;
    logic [L:2][RW-1:0] dest_q, dest_d, dest_sh;
    logic               load2_q, load2_d, squash_q, squash_d;
    logic [CNT_W-1:0]   stall_q, stall_d, flush_q, flush_d;
    logic               br_acc, hit, haz, fe, take;
    always_comb begin
        br_acc = pif.br_taken && valid_q[BR_STAGE] && !(pif.mem_stall && MEM_STAGE >= BR_STAGE);
        hit = 1'b0;
        for (int r = 2; r <= L; r++)
            if (r <= LAST && (FORWARD == 0 || r == 2))
                hit = hit || (valid_q[r] && we_q[r] && (FORWARD == 0 || load2_q) &&
                    ((pif.id_src_a_en && pif.id_src_a == dest_q[r]) ||
                     (pif.id_src_b_en && pif.id_src_b == dest_q[r])));
        haz = valid_q[1] && !br_acc && !pif.mem_stall && hit;
        fe = !pif.mem_stall && !br_acc && !haz;
        take = fe && pif.if_resp && !squash_q;
        // a taken branch squashes every younger register, overriding any memory hold
        for (int r = 1; r <= L; r++) begin
            hold_w[r] = !br_acc && ((pif.mem_stall && r <= MEM_STAGE) || (haz && r == 1));
            bub_w[r] = (br_acc && r <= BR_STAGE) || (pif.mem_stall && r == MEM_STAGE + 1) || (haz && r == 2);
        end
        valid_d = reset ? '0 : (valid_q & hold_w) | ({valid_q[L-1:1], take} & ~hold_w & ~bub_w);
        we_sh = {we_q[L-1:2], pif.id_we};
        we_d = (we_q & hold_w[L:2]) | (we_sh & ~hold_w[L:2]);
        dest_sh = {dest_q[L-1:2], pif.id_dest};
        dest_d = dest_q;
        for (int r = 2; r <= L; r++)
            dest_d[r] = hold_w[r] ? dest_q[r] : dest_sh[r];
        load2_d = hold_w[2] ? load2_q : pif.id_is_load;
        squash_d = br_acc ? !pif.if_resp : squash_q && !(fe && pif.if_resp);
        stall_d = ((pif.mem_stall || haz) && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
        flush_d = (br_acc && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            we_q     <= '0;
            dest_q   <= '0;
            load2_q  <= 1'b0;
            squash_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            dest_q   <= dest_d;
            load2_q  <= load2_d;
            squash_q <= squash_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end
    assign pif.load_pc      = !reset && (br_acc || take);
    assign pif.pc_sel       = br_acc;
    assign pif.pipe_load    = reset ? '1 : ~hold_w;
    assign pif.pipe_valid   = valid_q;
    assign pif.hazard_stall = haz;
    assign pif.retire_we    = valid_q[L] & we_q[L];
    assign pif.retire_dest  = dest_q[L];
    assign pif.stall_count  = stall_q;
    assign pif.flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench; dut0 full interlock, dut1 forwarding, dut2 RF bypass.
module tb_pipe_ctrl;
    localparam int CW = 4;
    localparam int F_VALID = 0, F_LOAD = 1, F_LPC = 2, F_SEL = 3, F_HAZ = 4;
    localparam int F_RWE = 5, F_RDEST = 6, F_STALL = 7, F_FLUSH = 8;
    localparam int LO [9] = '{0, 4, 8, 9, 10, 11, 12, 15, 19};
    localparam int WD [9] = '{4, 4, 1, 1, 1, 1, 3, 4, 4};
    typedef struct {
        string       tag;
        int          d;
        int          f;
        logic [31:0] v;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst, if_resp, mem_stall, br_taken;
    logic        id_we, id_is_load, a_en, b_en;
    logic [2:0]  id_dest, src_a, src_b;
    logic [31:0] obs [3];
    logic [8:0]  we_pat = 9'b1_0110_1100;
    exp_t        sb [$];
    int          n_vec = 0, n_bad = 0;
    always #5 clk = ~clk;
    for (genvar i = 0; i < 3; i++) begin : g
        pipe_ctrl_if #(.CNT_W(CW)) pif ();
        assign pif.if_resp     = if_resp;
        assign pif.mem_stall   = mem_stall;
        assign pif.br_taken    = br_taken;
        assign pif.id_we       = id_we;
        assign pif.id_dest     = id_dest;
        assign pif.id_is_load  = id_is_load;
        assign pif.id_src_a    = src_a;
        assign pif.id_src_a_en = a_en;
        assign pif.id_src_b    = src_b;
        assign pif.id_src_b_en = b_en;
        pipe_ctrl #(.FORWARD(i == 1 ? 1 : 0), .RF_BYPASS(i == 2 ? 1 : 0), .CNT_W(CW)) dut (
            .clk(clk), .reset(rst), .pif(pif)
        );
        assign obs[i] = {9'd0, pif.flush_count, pif.stall_count, pif.retire_dest, pif.retire_we,
                         pif.hazard_stall, pif.pc_sel, pif.load_pc, pif.pipe_load, pif.pipe_valid};
    end
    function automatic logic [31:0] get(input int d, input int f);
        return (obs[d] >> LO[f]) & ((32'd1 << WD[f]) - 32'd1);
    endfunction
    task automatic drv(input logic r, input logic fr, input logic ms, input logic bt);
        rst = r;
        if_resp = fr;
        mem_stall = ms;
        br_taken = bt;
    endtask
    task automatic dec(input logic we, input logic [2:0] dst, input logic ld,
                       input logic [2:0] sa, input logic sae, input logic [2:0] sbv, input logic sbe);
        id_we = we;
        id_dest = dst;
        id_is_load = ld;
        src_a = sa;
        a_en = sae;
        src_b = sbv;
        b_en = sbe;
    endtask
    task automatic ex(input string tag, input int d, input int f, input logic [31:0] v);
        sb.push_back('{tag, d, f, v});
    endtask
    task automatic step();
        exp_t e;
        logic [31:0] got;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = get(e.d, e.f);
            n_vec++;
            assert (got === e.v) else begin
                n_bad++;
                $error("FAIL %s dut%0d got %0h want %0h", e.tag, e.d, got, e.v);
            end
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        drv(1, 1, 0, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        ex("rst_lpc", 0, F_LPC, 0);
        ex("rst_load", 0, F_LOAD, 4'hf);
        step();
    endtask
    task automatic fill3();
        for (int k = 0; k < 3; k++) begin
            drv(0, 1, 0, 0);
            step();
        end
    endtask
    initial begin
        do_reset();
        for (int j = 1; j <= 8; j++) begin
            drv(0, 1, 0, 0);
            dec(we_pat[j], j[2:0], 0, 0, 0, 0, 0);
            ex("fill_valid", 0, F_VALID, j >= 5 ? 32'hf : 32'((1 << (j - 1)) - 1));
            ex("fill_lpc", 0, F_LPC, 1);
            ex("fill_haz", 0, F_HAZ, 0);
            ex("fill_rwe", 0, F_RWE, j >= 5 ? 32'(we_pat[j - 3]) : 32'd0);
            if (j >= 5 && we_pat[j - 3]) ex("fill_rdest", 0, F_RDEST, j - 3);
            step();
        end
        ex("fill_stall", 0, F_STALL, 0);
        ex("fill_flush", 0, F_FLUSH, 0);
        do_reset();
        drv(0, 1, 0, 0);
        ex("post_rst_valid", 1, F_VALID, 0);
        step();
        dec(1, 1, 1, 0, 0, 0, 0);
        ex("fwd_pre_haz", 1, F_HAZ, 0);
        step();
        drv(0, 0, 0, 0);
        dec(0, 0, 0, 1, 1, 0, 0);
        ex("fwd_haz", 1, F_HAZ, 1);
        ex("fwd_load", 1, F_LOAD, 4'b1110);
        ex("fwd_lpc", 1, F_LPC, 0);
        step();
        ex("fwd_haz_off", 1, F_HAZ, 0);
        ex("fwd_valid", 1, F_VALID, 4'b0101);
        ex("fwd_stall", 1, F_STALL, 1);
        step();
        do_reset();
        drv(0, 1, 0, 0);
        dec(0, 0, 0, 0, 0, 0, 0);
        step();
        dec(1, 3, 0, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0);
            dec(0, 0, 0, 5, 1, 3, 1);
            ex("raw_haz", 0, F_HAZ, k < 3);
            ex("byp_haz", 2, F_HAZ, k < 2);
            if (k == 2) ex("raw_rwe", 0, F_RWE, 1);
            if (k == 2) ex("raw_rdest", 0, F_RDEST, 3);
            step();
        end
        dec(0, 0, 0, 0, 0, 0, 0);
        ex("raw_stall", 0, F_STALL, 3);
        ex("byp_stall", 2, F_STALL, 2);
        do_reset();
        fill3();
        for (int k = 0; k < 3; k++) begin
            drv(0, 1, 1, 0);
            ex("ms_valid", 0, F_VALID, 4'b0111);
            ex("ms_load", 0, F_LOAD, 4'b1000);
            ex("ms_lpc", 0, F_LPC, 0);
            step();
        end
        drv(0, 1, 0, 0);
        ex("ms_end_valid", 0, F_VALID, 4'b0111);
        ex("ms_stall", 0, F_STALL, 3);
        ex("ms_resume_lpc", 0, F_LPC, 1);
        ex("ms_resume_load", 0, F_LOAD, 4'hf);
        step();
        ex("ms_resume_valid", 0, F_VALID, 4'hf);
        step();
        do_reset();
        fill3();
        drv(0, 1, 0, 1);
        ex("br_lpc", 0, F_LPC, 1);
        ex("br_sel", 0, F_SEL, 1);
        ex("br_load", 0, F_LOAD, 4'hf);
        step();
        drv(0, 1, 0, 0);
        ex("br_valid", 0, F_VALID, 4'b1000);
        ex("br_flush", 0, F_FLUSH, 1);
        ex("br_next_lpc", 0, F_LPC, 1);
        ex("br_next_sel", 0, F_SEL, 0);
        step();
        do_reset();
        fill3();
        drv(0, 0, 0, 1);
        step();
        drv(0, 0, 0, 0);
        ex("sq_valid", 0, F_VALID, 4'b1000);
        ex("sq_idle_lpc", 0, F_LPC, 0);
        step();
        step();
        drv(0, 1, 0, 0);
        ex("sq_drop_lpc", 0, F_LPC, 0);
        ex("sq_drop_load", 0, F_LOAD, 4'hf);
        step();
        ex("sq_drop_valid", 0, F_VALID, 0);
        ex("sq_accept_lpc", 0, F_LPC, 1);
        step();
        ex("sq_accept_valid", 0, F_VALID, 4'b0001);
        step();
        ex("run_valid", 0, F_VALID, 4'b0011);
        step();
        drv(1, 1, 0, 0);
        ex("midrst_valid", 0, F_VALID, 4'b0111);
        ex("midrst_lpc", 0, F_LPC, 0);
        ex("midrst_load", 0, F_LOAD, 4'hf);
        ex("midrst_flush", 0, F_FLUSH, 1);
        step();
        drv(0, 0, 0, 0);
        ex("midrst_cleared", 0, F_VALID, 0);
        ex("midrst_flush_clr", 0, F_FLUSH, 0);
        step();
        for (int k = 0; k < 17; k++) begin
            drv(0, 0, 1, 0);
            if (k == 14) ex("sat_mid", 0, F_STALL, 14);
            step();
        end
        drv(0, 0, 0, 0);
        for (int d = 0; d < 3; d++) ex("sat_stall", d, F_STALL, 15);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
